id_ex_stage_reg: RTL
====================

Name: id_ex_stage_reg

Overview:
Decode-to-execute pipeline register that sits directly downstream of the decode stage's hazard scoreboard. It captures one decoded instruction per handshake from ID and presents it to EX with a valid/ready interface. When the scoreboard reports a RAW hazard, it inserts a side-effect-free bubble. On a control redirect it kills the younger instruction. It also exports an issue pulse for scoreboard bookkeeping and saturating performance counters.

Parameters:
XLEN, 32, datapath width of pc/operand/immediate fields
CTRL_W, 16, width of opaque decoded control bundle passed to EX
CNT_W, 32, width of each performance counter (saturating)

Ports:
clk  in  1  clock
rst  in  1  reset
id_valid  in  1  ID holds a decoded instruction
id_ready  out  1  this stage can take the ID instruction this cycle
id_pc  in  XLEN  instruction PC
id_inst  in  32  raw instruction
id_rs1_val  in  XLEN  rs1 operand
id_rs2_val  in  XLEN  rs2 operand
id_imm  in  XLEN  decoded immediate
id_rd  in  5  destination register
id_rf_wen  in  1  instruction writes rd
id_ctrl  in  CTRL_W  decoded control bundle
hazard_stall  in  1  scoreboard RAW hazard on the current ID instruction
redirect  in  1  EX-resolved control transfer; kill younger work
issue_fire  out  1  ID instruction accepted this cycle (scoreboard reservation strobe)
ex_valid  out  1  EX register holds a valid instruction
ex_ready  in  1  EX consumes ex_* this cycle when ex_valid
ex_pc, ex_inst, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_rf_wen, ex_ctrl  out  matching widths  registered payload
stall_cnt  out  CNT_W  cycles with id_valid && hazard_stall
bubble_cnt  out  CNT_W  bubbles inserted into EX
issue_cnt  out  CNT_W  instructions issued to EX

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. All ex_* outputs, including ex_valid and ex_rf_wen, are 0. All counters are 0. A reset asserted mid-operation discards the held instruction in the same edge.
- Definitions:
  - adv = !ex_valid || ex_ready (the EX slot frees this cycle).
  - id_ready = adv && !hazard_stall && !redirect.
  - issue_fire = id_valid && id_ready. This is combinational and has zero latency.
- Per rising edge, in priority order:
  1. redirect: ex_valid<=0 and ex_rf_wen<=0. The ID instruction is not captured and issue_fire=0. redirect is legal only in a cycle where ex_valid && ex_ready, because the redirecting instruction completes. The bench asserts this as a protocol check.
  2. adv && issue_fire: capture the full payload and set ex_valid<=1. ex_rf_wen<=id_rf_wen && (id_rd!=0).
  3. adv && !issue_fire: ex_valid<=0 and ex_rf_wen<=0 (bubble). Other payload fields hold their values. If id_valid && hazard_stall, bubble_cnt increments.
  4. !adv: hold all ex_* unchanged (backpressure). ID sees id_ready=0.
- Latency: one cycle from issue_fire to ex_valid. Back-to-back issue is allowed every cycle when ex_ready=1.
- Payload is stable whenever ex_valid=1 && ex_ready=0.
- ex_rf_wen is never 1 while ex_valid is 0.
- Counters:
  - stall_cnt +1 on id_valid && hazard_stall && !redirect.
  - issue_cnt +1 on issue_fire.
  - bubble_cnt per rule 3.
  - All counters saturate at 2^CNT_W-1 with no wrap.
- hazard_stall with id_valid=0 has no effect other than holding id_ready low.

Test Plan:
- Streaming: ex_ready=1, no hazards, 4 instructions with pc 0x0,0x4,0x8,0xC -> ex_pc matches each one cycle later; ex_valid continuously 1; issue_cnt=4; bubble_cnt=0.
- Hazard bubble: id_valid=1, hazard_stall=1 for 2 cycles, then 0 -> id_ready=0 and issue_fire=0 for 2 cycles; EX sees 2 bubbles (ex_valid=0, ex_rf_wen=0); stall_cnt=2, bubble_cnt=2; instruction issues on cycle 3.
- Backpressure: ex_valid=1, ex_ready=0 for 3 cycles, id_valid=1 with pc 0x40 -> ex_* held stable; id_ready=0; pc 0x40 appears only the cycle after ex_ready returns to 1; stall_cnt unchanged.
- Redirect: EX holds a branch, ex_ready=1, redirect=1, id_valid=1 with pc 0x10 -> issue_fire=0; next cycle ex_valid=0; pc 0x10 is never presented; issue_cnt unchanged.
- x0 write: issue id_rd=0, id_rf_wen=1 -> ex_valid=1, ex_rf_wen=0.
- Saturation and reset: with CNT_W=4, hold hazard for 20 cycles -> stall_cnt=15, with no wrap. Then assert rst while ex_valid=1 -> next edge ex_valid=0 and all counters=0.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register: valid/ready handshake, hazard bubbles, redirect kill,
// scoreboard issue strobe and saturating performance counters.
module id_ex_stage_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  // decode side
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [31:0]       id_inst,
  input  logic [XLEN-1:0]   id_rs1_val,
  input  logic [XLEN-1:0]   id_rs2_val,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rd,
  input  logic              id_rf_wen,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              hazard_stall,
  input  logic              redirect,
  output logic              issue_fire,
  // execute side
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_pc,
  output logic [31:0]       ex_inst,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rd,
  output logic              ex_rf_wen,
  output logic [CTRL_W-1:0] ex_ctrl,
  // performance counters
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  issue_cnt
);

  localparam int NUM_CNT = 3;
  localparam int CNT_STALL  = 0;
  localparam int CNT_BUBBLE = 1;
  localparam int CNT_ISSUE  = 2;

  logic              ex_valid_reg;
  logic              ex_rf_wen_reg;
  logic [XLEN-1:0]   ex_pc_reg;
  logic [31:0]       ex_inst_reg;
  logic [XLEN-1:0]   ex_rs1_val_reg;
  logic [XLEN-1:0]   ex_rs2_val_reg;
  logic [XLEN-1:0]   ex_imm_reg;
  logic [4:0]        ex_rd_reg;
  logic [CTRL_W-1:0] ex_ctrl_reg;

  logic adv;
  logic stall_hit;
  logic [NUM_CNT-1:0] cnt_inc;
  logic [CNT_W-1:0]   cnt_reg [NUM_CNT];

  // The EX slot frees when it is empty or being consumed this cycle.
  assign adv        = !ex_valid_reg || ex_ready;
  assign id_ready   = adv && !hazard_stall && !redirect;
  assign issue_fire = id_valid && id_ready;
  assign stall_hit  = id_valid && hazard_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_reg   <= 1'b0;
      ex_rf_wen_reg  <= 1'b0;
      ex_pc_reg      <= '0;
      ex_inst_reg    <= '0;
      ex_rs1_val_reg <= '0;
      ex_rs2_val_reg <= '0;
      ex_imm_reg     <= '0;
      ex_rd_reg      <= '0;
      ex_ctrl_reg    <= '0;
    end else if (redirect) begin
      ex_valid_reg  <= 1'b0;
      ex_rf_wen_reg <= 1'b0;
    end else if (adv) begin
      if (issue_fire) begin
        ex_valid_reg   <= 1'b1;
        // Writes to x0 are dropped here so EX never needs to special-case them.
        ex_rf_wen_reg  <= id_rf_wen && (id_rd != 5'd0);
        ex_pc_reg      <= id_pc;
        ex_inst_reg    <= id_inst;
        ex_rs1_val_reg <= id_rs1_val;
        ex_rs2_val_reg <= id_rs2_val;
        ex_imm_reg     <= id_imm;
        ex_rd_reg      <= id_rd;
        ex_ctrl_reg    <= id_ctrl;
      end else begin
        ex_valid_reg  <= 1'b0;
        ex_rf_wen_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    cnt_inc             = '0;
    cnt_inc[CNT_STALL]  = stall_hit && !redirect;
    cnt_inc[CNT_BUBBLE] = stall_hit && !redirect && adv && !issue_fire;
    cnt_inc[CNT_ISSUE]  = issue_fire;
  end

  generate
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (rst)
          cnt_reg[gi] <= '0;
        else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}}))
          cnt_reg[gi] <= cnt_reg[gi] + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  endgenerate

  assign ex_valid   = ex_valid_reg;
  assign ex_rf_wen  = ex_rf_wen_reg;
  assign ex_pc      = ex_pc_reg;
  assign ex_inst    = ex_inst_reg;
  assign ex_rs1_val = ex_rs1_val_reg;
  assign ex_rs2_val = ex_rs2_val_reg;
  assign ex_imm     = ex_imm_reg;
  assign ex_rd      = ex_rd_reg;
  assign ex_ctrl    = ex_ctrl_reg;

  assign stall_cnt  = cnt_reg[CNT_STALL];
  assign bubble_cnt = cnt_reg[CNT_BUBBLE];
  assign issue_cnt  = cnt_reg[CNT_ISSUE];

endmodule
